// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types for the load/store unit: access sizes, FSM states
//               and the alignment helper used by the optional misalign trap.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } lsu_size_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } lsu_state_t;

    localparam int c_DATA_WIDTH = 32;

    // True when the low address bits are not a multiple of the access size.
    function automatic logic isMisaligned(input lsu_size_t size, input logic [1:0] addrLow);
        logic result;
        result = 1'b0;
        case (size)
            SIZE_HALF: result = addrLow[0];
            SIZE_WORD: result = |addrLow;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Little-endian lane extract/extend for loads and lane merge of
//               store data into the previously read word (purely combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_size_t   size,
    input  logic        isUnsigned,
    input  logic [1:0]  addrLow,
    input  logic [31:0] readWord,
    input  logic [31:0] writeData,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = readWord[7:0];
        case (addrLow)
            2'd0:    w_byte = readWord[7:0];
            2'd1:    w_byte = readWord[15:8];
            2'd2:    w_byte = readWord[23:16];
            default: w_byte = readWord[31:24];
        endcase
        w_half = addrLow[1] ? readWord[31:16] : readWord[15:0];
    end

    always_comb begin
        loadData = readWord;
        case (size)
            SIZE_BYTE: loadData = {{24{w_byte[7] & ~isUnsigned}}, w_byte};
            SIZE_HALF: loadData = {{16{w_half[15] & ~isUnsigned}}, w_half};
            default:   loadData = readWord;
        endcase
    end

    // Only the addressed lanes take store data; the rest keep the read word.
    always_comb begin
        mergedWord = readWord;
        case (size)
            SIZE_BYTE: begin
                case (addrLow)
                    2'd0:    mergedWord = {readWord[31:8], writeData[7:0]};
                    2'd1:    mergedWord = {readWord[31:16], writeData[7:0], readWord[7:0]};
                    2'd2:    mergedWord = {readWord[31:24], writeData[7:0], readWord[15:0]};
                    default: mergedWord = {writeData[7:0], readWord[23:0]};
                endcase
            end
            SIZE_HALF: mergedWord = addrLow[1] ? {writeData[15:0], readWord[15:0]}
                                               : {readWord[31:16], writeData[15:0]};
            default:   mergedWord = writeData;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit onto a word-wide memory
//               port, with read-modify-write for sub-word stores.
//               Define LSU_MISALIGN_TRAP_EN to turn misaligned accesses into
//               error responses instead of silently truncating the address.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int RAM_SELECT_BIT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqWriteData,
    output logic        respValid,
    output logic [31:0] respReadData,
    output logic        respError,
    output logic [31:0] memAddress,
    output logic        memReadEnable,
    output logic        memWriteEnable,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut
);

    lsu_state_t  r_state;
    lsu_state_t  w_nextState;

    logic        r_write;
    lsu_size_t   r_size;
    logic        r_unsigned;
    logic [31:0] r_address;
    logic [31:0] r_writeData;
    logic        r_error;
    logic [31:0] r_readWord;

    logic        w_accept;
    logic        w_reqError;
    lsu_size_t   w_reqSize;
    logic [31:0] w_loadData;
    logic [31:0] w_mergedWord;

    assign w_reqSize = lsu_size_t'(reqSize);
    assign w_accept  = reqValid && (r_state == IDLE);

    // Errors are decided at acceptance so the FSM can go straight to RESP.
    always_comb begin
        w_reqError = (w_reqSize == SIZE_RSVD) || (reqWrite && !reqAddress[RAM_SELECT_BIT]);
`ifdef LSU_MISALIGN_TRAP_EN
        w_reqError = w_reqError || isMisaligned(w_reqSize, reqAddress[1:0]);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_reqError)
                        w_nextState = RESP;
                    else if (reqWrite && (w_reqSize == SIZE_WORD))
                        w_nextState = WRITE;
                    else
                        w_nextState = RD_ADDR;
                end
            end
            RD_ADDR: w_nextState = RD_DATA;
            RD_DATA: w_nextState = r_write ? WRITE : RESP;
            WRITE:   w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write     <= 1'b0;
            r_size      <= SIZE_BYTE;
            r_unsigned  <= 1'b0;
            r_address   <= 32'h0;
            r_writeData <= 32'h0;
            r_error     <= 1'b0;
            r_readWord  <= 32'h0;
        end else begin
            if (w_accept) begin
                r_write     <= reqWrite;
                r_size      <= w_reqSize;
                r_unsigned  <= reqUnsigned;
                r_address   <= reqAddress;
                r_writeData <= reqWriteData;
                r_error     <= w_reqError;
            end
            if (r_state == RD_DATA) begin
                r_readWord <= memDataOut;
            end
        end
    end

    lsu_lane_align u_laneAlign (
        .size       (r_size),
        .isUnsigned (r_unsigned),
        .addrLow    (r_address[1:0]),
        .readWord   (r_readWord),
        .writeData  (r_writeData),
        .loadData   (w_loadData),
        .mergedWord (w_mergedWord)
    );

    always_comb begin
        reqReady       = (r_state == IDLE);
        memReadEnable  = (r_state == RD_ADDR) || (r_state == RD_DATA);
        memWriteEnable = (r_state == WRITE);
        memAddress     = 32'h0;
        memDataIn      = 32'h0;
        respValid      = (r_state == RESP);
        respError      = (r_state == RESP) && r_error;
        respReadData   = 32'h0;
        if ((r_state == RD_ADDR) || (r_state == RD_DATA) || (r_state == WRITE)) begin
            memAddress = {r_address[31:2], 2'b00};
        end
        if (r_state == WRITE) begin
            memDataIn = w_mergedWord;
        end
        if ((r_state == RESP) && !r_error && !r_write) begin
            respReadData = w_loadData;
        end
    end

endmodule
`default_nettype wire
